tvip_axi_sram_slave: RTL
========================

Name: tvip_axi_sram_slave

Overview:
- Synthesizable AXI4 slave with internal word-addressed memory.
- Sits directly downstream of the AXI interface bundle and connects to its slave-side signals.
- Serves as the reference DUT that the master agent drives in self-checking tests.
- Write and read paths are independent FSMs. Each path handles one outstanding burst; there is no interleaving and no reordering.

Parameters:
- ID_WIDTH, 4, width of awid/bid/arid/rid.
- ADDRESS_WIDTH, 12, byte-address bits decoded. Upper address bits are ignored, so access wraps modulo 2^ADDRESS_WIDTH.
- DATA_WIDTH, 32, data bus width. Legal values: 8/16/32/64/128/256/512/1024.
- MEMORY_DEPTH, derived: 2^ADDRESS_WIDTH / (DATA_WIDTH/8) words. Not overridable.

Ports:
- aclk  in  1  clock.
- areset_n  in  1  reset, asynchronous, active-low.
- awvalid in 1; awready out 1; awid in ID_WIDTH; awaddr in ADDRESS_WIDTH; awlen in 8; awsize in 3; awburst in 2; awqos in 4 (ignored).
- wvalid in 1; wready out 1; wdata in DATA_WIDTH; wstrb in DATA_WIDTH/8; wlast in 1.
- bvalid out 1; bready in 1; bid out ID_WIDTH; bresp out 2.
- arvalid in 1; arready out 1; arid in ID_WIDTH; araddr in ADDRESS_WIDTH; arlen in 8; arsize in 3; arburst in 2; arqos in 4 (ignored).
- rvalid out 1; rready in 1; rid out ID_WIDTH; rdata out DATA_WIDTH; rresp out 2; rlast out 1.

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - All outputs are 0 and both FSMs are in IDLE.
  - Memory contents are not cleared.
  - awready and arready rise on the first aclk edge after release.
- Handshake: a transfer occurs on any rising edge where valid && ready. Once asserted, slave valid and payload are held until the handshake.
- Write FSM, states W_IDLE → W_DATA → W_RESP:
  - W_IDLE: awready=1. On AW handshake, latch id/addr/len/size/burst, set awready=0, go to W_DATA. wready=1 from the next cycle.
  - W_DATA: on each W handshake, store the bytes whose wstrb bit is set to the current word (only if the burst is legal), then advance the address.
  - Exit W_DATA on a handshake with wlast=1. Then wready=0 and bvalid=1 with bid=latched id in the next cycle (W_RESP).
  - W_RESP: on B handshake go to W_IDLE; awready=1 in the next cycle.
  - Minimum AW-to-AW spacing is 3+len cycles.
- Read FSM, states R_IDLE → R_DATA:
  - R_IDLE: arready=1. On AR handshake, latch the fields, set arready=0, go to R_DATA.
  - The first rvalid appears in the cycle after AR acceptance.
  - rdata is a registered snapshot of memory taken when the beat is loaded, held stable under rready=0.
  - rlast=1 on beat number len (0-based).
  - The next beat is presented in the cycle after each R handshake, so back-to-back is possible with rready held high.
  - After the rlast handshake: rvalid=0, arready=1 in the next cycle.
- Address update, with beat size 2^size bytes:
  - FIXED(0): address held.
  - INCR(1): addr += 2^size, wrapping at 2^ADDRESS_WIDTH.
  - WRAP(2): addr = (addr & ~(blk-1)) | ((addr+2^size) & (blk-1)), where blk = (len+1)·2^size.
  - Word index = addr >> log2(DATA_WIDTH/8).
- Error rules (bresp/rresp = SLVERR 2'b10, otherwise OKAY 2'b00). Any of these conditions triggers SLVERR:
  - burst = 2'b11;
  - size > log2(DATA_WIDTH/8);
  - WRAP with len not in {1,3,7,15};
  - write beats not matching len+1 (wlast early, or missing at beat len).
- Error handling:
  - On an error burst, write data is consumed and discarded, and no memory update happens.
  - If wlast is missing at beat len, beats continue to be accepted and discarded until wlast.
  - Read error bursts return len+1 beats with rdata=0 and SLVERR on every beat.
- Simultaneous read/write to the same word: a read beat loaded in the same cycle as a write to that word returns the pre-write value.
- Reset asserted mid-burst: the burst is abandoned immediately, and no B or R beat is produced after release.

Test Plan:
- Write addr 0x010, len 0, size 2, INCR, wdata 0xDEADBEEF, wstrb 0xF, then read addr 0x010 → bresp 0, rdata 0xDEADBEEF, rresp 0, rlast 1, rid = arid.
- INCR burst at 0x100, len 3, data 0x1..0x4, then read len 3 → rdata 1,2,3,4 in order, rlast only on the 4th beat. Repeat with rready toggling every cycle: data stable while stalled.
- WRAP burst at 0x108, len 3, size 2 → words written at 0x108, 0x10C, 0x100, 0x104. Readback via INCR at 0x100 returns beats 3,4,1,2.
- Partial strobe: write 0xAABBCCDD with wstrb 0x5 over 0x00000000 → readback 0x00BB00DD.
- awburst=2'b11, len 1 → both beats accepted, bresp 2'b10, memory unchanged. arburst=2'b11, len 2 → 3 beats, rdata 0, rresp 2'b10.
- Drop areset_n during beat 2 of a len-7 read → rvalid falls to 0 asynchronously. After release, arready=1 at the first edge and no stray R beat appears.

Source files
------------

// File: rtl/tvip_axi_sram_slave.sv
// tvip_axi_sram_slave: AXI4 slave backed by a word-addressed internal SRAM
module tvip_axi_sram_slave #(
  parameter int ID_WIDTH      = 4,
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                      aclk,
  input  logic                      areset_n,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [ID_WIDTH-1:0]       awid,
  input  logic [ADDRESS_WIDTH-1:0]  awaddr,
  input  logic [7:0]                awlen,
  input  logic [2:0]                awsize,
  input  logic [1:0]                awburst,
  input  logic [3:0]                awqos,
  input  logic                      wvalid,
  output logic                      wready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wlast,
  output logic                      bvalid,
  input  logic                      bready,
  output logic [ID_WIDTH-1:0]       bid,
  output logic [1:0]                bresp,
  input  logic                      arvalid,
  output logic                      arready,
  input  logic [ID_WIDTH-1:0]       arid,
  input  logic [ADDRESS_WIDTH-1:0]  araddr,
  input  logic [7:0]                arlen,
  input  logic [2:0]                arsize,
  input  logic [1:0]                arburst,
  input  logic [3:0]                arqos,
  output logic                      rvalid,
  input  logic                      rready,
  output logic [ID_WIDTH-1:0]       rid,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rlast
);
  localparam int STRB_WIDTH   = DATA_WIDTH / 8;
  localparam int LSB          = $clog2(STRB_WIDTH);
  localparam int MEMORY_DEPTH = (2 ** ADDRESS_WIDTH) / STRB_WIDTH;
  localparam int IW           = ADDRESS_WIDTH - LSB;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  logic [DATA_WIDTH-1:0] mem [MEMORY_DEPTH];

  // Address of the following beat; FIXED holds, WRAP stays inside the (len+1)*2^size block
  function automatic logic [ADDRESS_WIDTH-1:0] next_addr(input logic [ADDRESS_WIDTH-1:0] a,
      input logic [2:0] s, input logic [1:0] b, input logic [7:0] l);
    logic [ADDRESS_WIDTH-1:0] inc, msk;
    inc = ADDRESS_WIDTH'(1) << s;
    msk = ((ADDRESS_WIDTH'(l) + ADDRESS_WIDTH'(1)) << s) - ADDRESS_WIDTH'(1);
    return (b == 2'd0) ? a : (b == 2'd2) ? ((a & ~msk) | ((a + inc) & msk)) : a + inc;
  endfunction

  function automatic logic illegal(input logic [1:0] b, input logic [2:0] s, input logic [7:0] l);
    return b == 2'd3 || s > 3'(LSB) || (b == 2'd2 && !(l inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  function automatic logic [IW-1:0] widx(input logic [ADDRESS_WIDTH-1:0] a);
    return a[ADDRESS_WIDTH-1:LSB];
  endfunction

  w_state_e                 w_state_q, w_state_d;
  logic                     awready_q, wready_q, bvalid_q, mem_we;
  logic [ID_WIDTH-1:0]      bid_q, bid_d;
  logic [ADDRESS_WIDTH-1:0] waddr_q, waddr_d;
  logic [7:0]               wlen_q, wlen_d;
  logic [2:0]               wsize_q, wsize_d;
  logic [1:0]               wburst_q, wburst_d;
  logic                     werr_q, werr_d, wbad_q, wbad_d;
  logic [8:0]               wcnt_q, wcnt_d;

  // Write FSM next state: latch AW, count beats, flag illegal bursts and length mismatches
  always_comb begin
    w_state_d = w_state_q;
    bid_d     = bid_q;
    waddr_d   = waddr_q;
    wlen_d    = wlen_q;
    wsize_d   = wsize_q;
    wburst_d  = wburst_q;
    werr_d    = werr_q;
    wbad_d    = wbad_q;
    wcnt_d    = wcnt_q;
    mem_we    = 1'b0;
    case (w_state_q)
      W_IDLE: if (awvalid && awready_q) begin
        w_state_d = W_DATA;
        bid_d     = awid;
        waddr_d   = awaddr;
        wlen_d    = awlen;
        wsize_d   = awsize;
        wburst_d  = awburst;
        werr_d    = illegal(awburst, awsize, awlen);
        wbad_d    = 1'b0;
        wcnt_d    = '0;
      end
      W_DATA: if (wvalid && wready_q) begin
        mem_we    = !werr_q && wcnt_q <= {1'b0, wlen_q};
        waddr_d   = next_addr(waddr_q, wsize_q, wburst_q, wlen_q);
        wcnt_d    = wcnt_q[8] ? wcnt_q : wcnt_q + 9'd1;
        wbad_d    = wbad_q || (wlast != (wcnt_q == {1'b0, wlen_q}));
        w_state_d = wlast ? W_RESP : W_DATA;
      end
      default: if (bvalid_q && bready) w_state_d = W_IDLE;
    endcase
  end

  // Write FSM registers; handshake outputs are registered decodes of the next state
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      werr_q    <= 1'b0;
      wbad_q    <= 1'b0;
      wcnt_q    <= '0;
    end else begin
      w_state_q <= w_state_d;
      awready_q <= w_state_d == W_IDLE;
      wready_q  <= w_state_d == W_DATA;
      bvalid_q  <= w_state_d == W_RESP;
      bid_q     <= bid_d;
      waddr_q   <= waddr_d;
      wlen_q    <= wlen_d;
      wsize_q   <= wsize_d;
      wburst_q  <= wburst_d;
      werr_q    <= werr_d;
      wbad_q    <= wbad_d;
      wcnt_q    <= wcnt_d;
    end
  end

  // Byte-lane writes into the SRAM; contents survive reset
  always_ff @(posedge aclk) begin
    if (mem_we)
      for (int i = 0; i < STRB_WIDTH; i++)
        if (wstrb[i]) mem[widx(waddr_q)][i*8 +: 8] <= wdata[i*8 +: 8];
  end

  r_state_e                 r_state_q, r_state_d;
  logic                     arready_q, rvalid_q, ar_hs, r_hs, ld, ld_err;
  logic [ADDRESS_WIDTH-1:0] ld_addr;
  logic [ID_WIDTH-1:0]      rid_q, rid_d;
  logic [ADDRESS_WIDTH-1:0] raddr_q, raddr_d;
  logic [7:0]               rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [2:0]               rsize_q, rsize_d;
  logic [1:0]               rburst_q, rburst_d;
  logic                     rerr_q, rerr_d, rlast_q, rlast_d;
  logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;

  assign ar_hs   = arvalid && arready_q;
  assign r_hs    = rvalid_q && rready;
  assign ld      = ar_hs || (r_hs && !rlast_q);
  assign ld_addr = ar_hs ? araddr : next_addr(raddr_q, rsize_q, rburst_q, rlen_q);
  assign ld_err  = ar_hs ? illegal(arburst, arsize, arlen) : rerr_q;

  // Read FSM next state: a beat is loaded on AR acceptance and after every non-last R handshake
  always_comb begin
    r_state_d = ar_hs ? R_DATA : (r_hs && rlast_q) ? R_IDLE : r_state_q;
    rid_d     = ar_hs ? arid : rid_q;
    rlen_d    = ar_hs ? arlen : rlen_q;
    rsize_d   = ar_hs ? arsize : rsize_q;
    rburst_d  = ar_hs ? arburst : rburst_q;
    rerr_d    = ld_err;
    rcnt_d    = ar_hs ? 8'd0 : ld ? rcnt_q + 8'd1 : rcnt_q;
    rlast_d   = ar_hs ? arlen == 8'd0 : ld ? (rcnt_q + 8'd1) == rlen_q : rlast_q;
    raddr_d   = ld ? ld_addr : raddr_q;
    rdata_d   = !ld ? rdata_q : ld_err ? '0 : mem[widx(ld_addr)];
  end

  // Read FSM registers; rdata is a snapshot taken at load time
  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rerr_q    <= 1'b0;
      rcnt_q    <= '0;
      rlast_q   <= 1'b0;
      rdata_q   <= '0;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= r_state_d == R_IDLE;
      rvalid_q  <= r_state_d == R_DATA;
      rid_q     <= rid_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      rburst_q  <= rburst_d;
      rerr_q    <= rerr_d;
      rcnt_q    <= rcnt_d;
      rlast_q   <= rlast_d;
      rdata_q   <= rdata_d;
    end
  end

  logic unused_qos;
  assign unused_qos = ^{awqos, arqos};

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bid     = bid_q;
  assign bresp   = {werr_q | wbad_q, 1'b0};
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rid     = rid_q;
  assign rdata   = rdata_q;
  assign rresp   = {rerr_q, 1'b0};
  assign rlast   = rlast_q;
endmodule
